// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Block-fill controller for a cache with 16-byte lines (8 x 16-bit words).
// On a miss it latches the block base address, issues eight word reads to main
// memory (stalling whenever the arbiter withholds mem_grant), and writes each
// returning word into the data array. The tag/valid array is written with the
// eighth returned word, and fill_done pulses in that same cycle.
//
// Ports
//   clk                in   system clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   miss_detected      in   cache miss, held by the cache until fill_done
//   miss_address[15:0] in   byte address of the miss, sampled on leaving IDLE
//   mem_grant          in   arbiter permission to use main memory this cycle
//   memory_data_valid  in   main memory read data valid
//   memory_data[15:0]  in   main memory read data
//   fsm_busy           out  fill in progress (pipeline stall)
//   mem_read           out  memory read request / arbiter request
//   memory_address[15:0] out word address being requested
//   write_data_array   out  data array write strobe
//   word_index[2:0]    out  word slot for the data array write
//   data_out[15:0]     out  data array write data (memory_data passthrough)
//   write_tag_array    out  tag/valid array write strobe (one-cycle pulse)
//   fill_done          out  block fill complete (one-cycle pulse)
// -----------------------------------------------------------------------------
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        mem_grant,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  word_index,
  output logic [15:0] data_out,
  output logic        write_tag_array,
  output logic        fill_done
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_GRANT = 2'd1;
  localparam logic [1:0] FILL       = 2'd2;

  logic [1:0]  state,     next_state;
  logic [15:0] base,      next_base;
  // issue_cnt counts accepted reads 0..8; bit 3 set means all issued.
  logic [3:0]  issue_cnt, next_issue_cnt;
  logic [2:0]  recv_cnt,  next_recv_cnt;

  assign data_out = memory_data;

  always_comb begin
    // NOTE: every output and next-state term gets a default here so that no
    // path through the case statement leaves a value unassigned (no latches).
    next_state       = state;
    next_base        = base;
    next_issue_cnt   = issue_cnt;
    next_recv_cnt    = recv_cnt;
    fsm_busy         = 1'b1;
    mem_read         = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    word_index       = 3'd0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state)
      IDLE: begin
        // Combinational busy stalls the pipeline in the miss cycle itself.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          next_state     = WAIT_GRANT;
          next_base      = miss_address & 16'hFFF0;
          next_issue_cnt = 4'd0;
          next_recv_cnt  = 3'd0;
        end
      end

      WAIT_GRANT: begin
        mem_read       = 1'b1;
        memory_address = base;
        if (mem_grant) begin
          next_issue_cnt = 4'd1;
          next_state     = FILL;
        end
      end

      FILL: begin
        // Issue side: keep requesting until eight reads have been accepted;
        // a withheld grant just holds the current address.
        if (!issue_cnt[3]) begin
          mem_read       = 1'b1;
          memory_address = base + {12'd0, issue_cnt[2:0], 1'b0};
          if (mem_grant) begin
            next_issue_cnt = issue_cnt + 4'd1;
          end
        end

        // Receive side runs independently of the issue side.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = recv_cnt;
          next_recv_cnt    = recv_cnt + 3'd1;
          if (recv_cnt == 3'd7) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            next_state      = IDLE;
          end
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE without strobing anything.
        fsm_busy   = miss_detected;
        next_state = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= 16'h0000;
      issue_cnt <= 4'd0;
      recv_cnt  <= 3'd0;
    end else begin
      state     <= next_state;
      base      <= next_base;
      issue_cnt <= next_issue_cnt;
      recv_cnt  <= next_recv_cnt;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Directed bench for cache_fill_fsm. A small memory model returns the word for
// each accepted read five clock edges after the issue cycle (request captured
// on the edge, then four cycles of access), and returns addr ^ 16'hA5A5 as data.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_grant;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic        fill_done;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_grant         (mem_grant),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .data_out          (data_out),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Per-fill observation records.
  int          cyc;
  int          start_cyc;
  int          done_cyc;
  int          n_issue, n_recv, n_tag, n_done, n_pause;
  logic [15:0] issued_addr [0:15];
  logic [2:0]  got_idx     [0:15];
  logic [15:0] got_data    [0:15];
  logic [15:0] pause_addr;

  // Memory model pipeline and stimulus controls.
  logic        pipe_v [0:4];
  logic [15:0] pipe_a [0:4];
  logic        pipe_in_v;
  logic [15:0] pipe_in_a;
  logic        done_now;
  logic        next_v;
  logic [15:0] next_a;
  int          drop_at, drop_left, mut_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_counts();
    n_issue = 0; n_recv = 0; n_tag = 0; n_done = 0; n_pause = 0;
    done_cyc = -1;
    pause_addr = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      issued_addr[i] = 16'h0000;
      got_idx[i]     = 3'd0;
      got_data[i]    = 16'h0000;
    end
  endtask

  // Observe one cycle's outputs on the falling edge.
  task automatic sample();
    @(negedge clk);
    pipe_in_v = 1'b0;
    pipe_in_a = 16'h0000;
    if (mem_read && mem_grant) begin
      if (n_issue < 16) issued_addr[n_issue] = memory_address;
      n_issue++;
      pipe_in_v = 1'b1;
      pipe_in_a = memory_address;
    end
    if (mem_read && !mem_grant) begin
      n_pause++;
      pause_addr = memory_address;
    end
    if (write_data_array) begin
      if (n_recv < 16) begin
        got_idx[n_recv]  = word_index;
        got_data[n_recv] = data_out;
      end
      n_recv++;
    end
    if (write_tag_array) n_tag++;
    if (fill_done) begin
      n_done++;
      done_cyc = cyc;
      done_now = 1'b1;
    end
  endtask

  // Cross the rising edge and drive the next cycle's inputs.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 4; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = pipe_in_v;
    pipe_a[0] = pipe_in_a;
    memory_data_valid = pipe_v[4];
    memory_data       = pipe_v[4] ? (pipe_a[4] ^ 16'hA5A5) : 16'h0000;
    if (drop_left > 0 && n_issue >= drop_at) begin
      mem_grant = 1'b0;
      drop_left--;
    end else begin
      mem_grant = 1'b1;
    end
    if (mut_at > 0 && n_issue == mut_at) begin
      miss_address = 16'hABCD;
      mut_at = 0;
    end
    if (done_now) begin
      miss_detected = next_v;
      miss_address  = next_v ? next_a : miss_address;
      next_v   = 1'b0;
      done_now = 1'b0;
    end
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Runs from the miss cycle (inputs already driven) until fill_done.
  task automatic run_fill(input int budget);
    clear_counts();
    start_cyc = cyc;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (n_done != 0) break;
    end
  endtask

  task automatic verify_fill(input string tag, input logic [15:0] base);
    check({tag, "_issues"}, n_issue, 8);
    check({tag, "_recvs"},  n_recv,  8);
    check({tag, "_tags"},   n_tag,   1);
    check({tag, "_dones"},  n_done,  1);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ea;
      ea = base + 16'(2 * k);
      check($sformatf("%s_addr%0d", tag, k), issued_addr[k], ea);
      check($sformatf("%s_idx%0d",  tag, k), got_idx[k],     k);
      check($sformatf("%s_data%0d", tag, k), got_data[k],    ea ^ 16'hA5A5);
    end
  endtask

  initial begin
    cyc = 0; drop_at = 0; drop_left = 0; mut_at = 0;
    done_now = 1'b0; next_v = 1'b0; next_a = 16'h0000;
    pipe_in_v = 1'b0; pipe_in_a = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 16'h0000;
    end
    clear_counts();
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    mem_grant = 1'b0;
    memory_data_valid = 1'b0;
    memory_data = 16'h0000;

    // Reset state; fsm_busy follows miss_detected even in reset.
    #3;
    check("rst_busy0",  fsm_busy,       0);
    check("rst_read",   mem_read,       0);
    check("rst_addr",   memory_address, 0);
    check("rst_wda",    write_data_array, 0);
    check("rst_tag",    write_tag_array,  0);
    check("rst_done",   fill_done,      0);
    check("rst_widx",   word_index,     0);
    miss_detected = 1'b1;
    #1;
    check("rst_busy1",  fsm_busy, 1);
    check("rst_read1",  mem_read, 0);
    miss_detected = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    advance();

    // Data valid while IDLE is ignored.
    memory_data_valid = 1'b1;
    memory_data = 16'h1111;
    #1;
    check("idle_valid_wda",  write_data_array, 0);
    check("idle_valid_widx", word_index,       0);
    check("idle_valid_busy", fsm_busy,         0);
    sample();
    advance();

    // Fill at 0x1234 with continuous grant; busy in the miss cycle itself.
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    #1;
    check("miss_cycle_busy", fsm_busy, 1);
    check("miss_cycle_read", mem_read, 0);
    run_fill(40);
    verify_fill("fill1", 16'h1230);
    check("fill1_latency", done_cyc - start_cyc, 13);
    #1;
    check("post_done_busy", fsm_busy, 0);
    check("post_done_read", mem_read, 0);
    cycle();

    // Grant dropped for 3 cycles after the 2nd issue; miss_address changes
    // to 0xABCD mid-fill.
    drop_at = 2; drop_left = 3; mut_at = 4;
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    run_fill(60);
    verify_fill("fill2", 16'h1230);
    check("fill2_pauses",     n_pause,    3);
    check("fill2_pause_addr", pause_addr, 16'h1234);
    cycle();

    // Back-to-back misses: second asserted the cycle after fill_done.
    miss_detected = 1'b1;
    miss_address  = 16'h0010;
    next_v = 1'b1;
    next_a = 16'h0100;
    run_fill(40);
    verify_fill("b2b_a", 16'h0010);
    #1;
    check("b2b_busy", fsm_busy, 1);
    run_fill(40);
    verify_fill("b2b_b", 16'h0100);
    cycle();

    // Reset after the 5th returned word abandons the fill.
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (n_recv >= 5) break;
    end
    check("pre_rst_recvs", n_recv, 5);
    rst_n = 1'b0;
    miss_detected = 1'b0;
    #1;
    check("mid_rst_read", mem_read,         0);
    check("mid_rst_addr", memory_address,   0);
    check("mid_rst_wda",  write_data_array, 0);
    check("mid_rst_tag",  write_tag_array,  0);
    check("mid_rst_done", fill_done,        0);
    check("mid_rst_widx", word_index,       0);
    check("mid_rst_busy", fsm_busy,         0);
    clear_counts();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check("post_rst_recvs", n_recv, 0);
    check("post_rst_tags",  n_tag,  0);

    // Fresh fill after reset at the top of the address space.
    miss_detected = 1'b1;
    miss_address  = 16'hFFF8;
    run_fill(40);
    verify_fill("fill_top", 16'hFFF0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; clears all state immediately, independent of clk.
REQ-003 miss_detected  input  1  cache lookup miss for the current access; level, held by the cache until fill_done.
REQ-004 miss_address  input  16  byte address of the missing access; sampled only when the FSM leaves IDLE.
REQ-005 mem_grant  input  1  arbiter permission to drive main memory this cycle.
REQ-006 memory_data_valid  input  1  main memory read data is valid this cycle.
REQ-007 memory_data  input  16  main memory read data.
REQ-008 fsm_busy  output  1  fill in progress; the pipeline stalls on this signal.
REQ-009 mem_read  output  1  read request to main memory; also the arbiter request.
REQ-010 memory_address  output  16  word address being requested.
REQ-011 write_data_array  output  1  write strobe for the cache data array.
REQ-012 word_index  output  3  word slot in the block for the current data-array write.
REQ-013 data_out  output  16  data to be written into the data array; equals memory_data.
REQ-014 write_tag_array  output  1  write strobe for the tag/valid array; single-cycle pulse.
REQ-015 fill_done  output  1  block fill complete; single-cycle pulse.

Function
REQ-016 Block geometry: 16-byte block, 8 x 16-bit words; block base = miss_address & 16'hFFF0.
REQ-017 States: IDLE, WAIT_GRANT, FILL; 2-bit encoding, no other reachable states.
REQ-018 IDLE transition: miss_detected=1 -> latch base, clear issue_cnt (4b) and recv_cnt (3b), next state WAIT_GRANT.
REQ-019 fsm_busy = miss_detected in IDLE (combinational), and 1 in WAIT_GRANT and FILL; this guarantees a stall in the miss cycle itself.
REQ-020 WAIT_GRANT: mem_read=1 and memory_address=base; mem_grant=1 -> the request is accepted, issue_cnt becomes 1, next state FILL.
REQ-021 FILL issue: while issue_cnt<8 and mem_grant=1 -> mem_read=1, memory_address = base + (issue_cnt<<1), and issue_cnt increments.
REQ-022 FILL issue pause: mem_grant=0 -> mem_read still asserted, issue_cnt holds, and no address advance.
REQ-023 Issue completion: issue_cnt==8 -> mem_read=0 and memory_address=16'h0000.
REQ-024 Receive: memory_data_valid=1 in FILL -> write_data_array=1, word_index=recv_cnt, recv_cnt increments (3-bit, wraps only on the final word).
REQ-025 Receive vs. issue: the receive path is independent of grant and issue state; issue and receive may occur in the same cycle.
REQ-026 Completion: memory_data_valid=1 with recv_cnt==7 -> write_tag_array=1 and fill_done=1 in the same cycle, next state IDLE.
REQ-027 Completion timing: fsm_busy deasserts the following cycle, unless a new miss is present.
REQ-028 memory_data_valid outside FILL is ignored: no strobes, no counter change.
REQ-029 miss_detected and miss_address changes while not IDLE are ignored; the latched base is never modified mid-fill.
REQ-030 A new miss asserted in the cycle after fill_done starts a new fill normally.
REQ-031 Outputs in IDLE and WAIT_GRANT: write_data_array, write_tag_array, fill_done all 0; word_index=0.
REQ-032 Minimum fill latency with 4-cycle memory and continuous grant: fill_done 13 cycles after the miss cycle (1 grant + 8 issue + 4 return).

Reset
REQ-033 rst_n=0 -> state IDLE, base=0, issue_cnt=0, recv_cnt=0, asynchronously.
REQ-034 Outputs during reset: mem_read=0, memory_address=0, write_data_array=0, write_tag_array=0, fill_done=0, word_index=0, fsm_busy=miss_detected.
REQ-035 Reset mid-fill abandons the fill, and no tag write occurs; any data returning after reset release is ignored per REQ-028.

Verification
REQ-036 Miss at 0x1234 with grant always 1 and memory latency 4 -> memory_address sequence 0x1230,0x1232,...,0x123E; word_index 0..7; one write_tag_array/fill_done pulse on the 8th valid.
REQ-037 Grant dropped for 3 cycles after the 2nd issue -> addresses resume at 0x1234 with no skips or duplicates; exactly 8 mem_read/grant cycles total.
REQ-038 memory_data_valid pulsed while IDLE -> no write_data_array, and recv_cnt stays 0.
REQ-039 rst_n low after the 5th returned word -> all outputs 0 immediately; a subsequent miss at 0xFFF8 fills 0xFFF0..0xFFFE with word_index restarting at 0.
REQ-040 Back-to-back misses 0x0010 then 0x0100 (second asserted the cycle after fill_done) -> two complete fills, each with exactly one tag write.
REQ-041 miss_address changed to 0xABCD mid-fill -> remaining addresses continue from the original base.
